multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences a shared-memory multi-cycle RV32I datapath: FETCH → DECODE → EXECUTE → MEM → WRITEBACK.
- Supports the same opcode subset as the single-cycle decoder: R-type 0110011, I-ALU 0010011, lw 0000011, sw 0100011, beq 1100011.
- Adds a ready handshake for variable-latency memory, a wait watchdog and a sticky fault state.
- Sits beside the register file, ALU and unified memory. Drives all mux selects and write strobes.

---
 rtl/riscv_ctrl_pkg.sv | 41 ++++
 rtl/mem_wait_watchdog.sv | 35 +++
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALU_WB   = 4'd8,
        ST_BEQ      = 4'd9,
        ST_FAULT    = 4'd10
    } state_t;

    // States that wait on mem_ready and are guarded by the watchdog.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Saturating wait counter for memory accesses; flags a timeout when the
// count reaches MEM_TIMEOUT with no ready (MEM_TIMEOUT=0 disables it).
module mem_wait_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] MAX_C   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Wait counter: cleared on entry, counts unready cycles, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && !ready && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && enable && !ready && (cnt_r == LIMIT_C);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with memory handshake, watchdog and sticky
// fault. Define MULTICYCLE_PERF_EN to add the instret retired-instruction counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       fault,
    output logic [3:0] state_o
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] instret
`endif
);

    state_t state_r;
    state_t next_state_s;
    logic   wd_timeout_s;
    logic   wd_clear_s;

    // The zero flag only qualifies branch in the datapath, not the sequencing.
    logic   zero_unused_s;
    assign zero_unused_s = zero;

    assign wd_clear_s = is_mem_state(next_state_s) && (next_state_s != state_r);

    mem_wait_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (is_mem_state(state_r)),
        .clear   (wd_clear_s),
        .ready   (mem_ready),
        .timeout (wd_timeout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; ready beats timeout in the same cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready)         next_state_s = ST_DECODE;
                else if (wd_timeout_s) next_state_s = ST_FAULT;
                else                   next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_s = ST_MEM_ADDR;
                    OP_R:         next_state_s = ST_EXEC_R;
                    OP_I:         next_state_s = ST_EXEC_I;
                    OP_BEQ:       next_state_s = ST_BEQ;
                    default:      next_state_s = ST_FAULT;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW)      next_state_s = ST_MEM_RD;
                else if (opcode == OP_SW) next_state_s = ST_MEM_WR;
                else                      next_state_s = ST_FAULT;
            end
            ST_MEM_RD: begin
                if (mem_ready)         next_state_s = ST_MEM_WB;
                else if (wd_timeout_s) next_state_s = ST_FAULT;
                else                   next_state_s = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (mem_ready)         next_state_s = ST_FETCH;
                else if (wd_timeout_s) next_state_s = ST_FAULT;
                else                   next_state_s = ST_MEM_WR;
            end
            ST_MEM_WB, ST_ALU_WB, ST_BEQ: next_state_s = ST_FETCH;
            ST_EXEC_R, ST_EXEC_I:         next_state_s = ST_ALU_WB;
            ST_FAULT:                     next_state_s = ST_FAULT;
            default:                      next_state_s = ST_FAULT;
        endcase
    end

    // Output decode; strobes are forced low while reset is held.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        pc_source  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                pc_source = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        pc_write  = pc_write  & ~reset;
        branch    = branch    & ~reset;
        ir_write  = ir_write  & ~reset;
        mem_read  = mem_read  & ~reset;
        mem_write = mem_write & ~reset;
        reg_write = reg_write & ~reset;
    end

    assign fault   = (state_r == ST_FAULT);
    assign state_o = state_r;

`ifdef MULTICYCLE_PERF_EN
    logic retire_s;
    assign retire_s = (next_state_s == ST_FETCH) &&
                      ((state_r == ST_MEM_WB) || (state_r == ST_MEM_WR) ||
                       (state_r == ST_ALU_WB) || (state_r == ST_BEQ));

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= 32'd0;
        end else if (retire_s) begin
            instret <= instret + 32'd1;
        end else begin
            instret <= instret;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_TIMEOUT=16).
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, branch, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, reg_write, pc_source, fault;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [3:0] state_o;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] instret;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .branch(branch),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .fault(fault), .state_o(state_o)
`ifdef MULTICYCLE_PERF_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    logic [19:0] outs;
    assign outs = {pc_write, branch, ir_write, iord, mem_read, mem_write,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, fault, state_o};

    // Expected output vector for a state, built from the state/output table.
    function automatic logic [19:0] exp_outs(input logic [3:0] st, input logic rdy, input logic rst);
        logic pcw, br, irw, io, mr, mw, mtr, rw, pcs, flt;
        logic [1:0] a, b, op;
        {pcw, br, irw, io, mr, mw, mtr, rw, pcs, flt} = 10'd0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; b = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  begin a = 2'b10; b = 2'b10; end
            4'd2:  begin a = 2'b01; b = 2'b10; end
            4'd3:  begin mr = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; mtr = 1'b1; end
            4'd5:  begin mw = 1'b1; io = 1'b1; end
            4'd6:  begin a = 2'b01; op = 2'b10; end
            4'd7:  begin a = 2'b01; b = 2'b10; op = 2'b10; end
            4'd8:  begin rw = 1'b1; end
            4'd9:  begin a = 2'b01; op = 2'b01; br = 1'b1; pcs = 1'b1; end
            4'd10: begin flt = 1'b1; end
            default: begin flt = 1'b0; end
        endcase
        if (rst) begin
            {pcw, br, irw, mr, mw, rw} = 6'd0;
        end
        return {pcw, br, irw, io, mr, mw, mtr, rw, a, b, op, pcs, flt, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        reset = 1'b1; mem_ready = 1'b1; opcode = OP_LW; zero = 1'b0;
        tick(); tick();
        e = exp_outs(4'd0, 1'b1, 1'b1);
        total_cnt++;
        if (outs !== e) $display("FAIL reset_held: got %h expected %h", outs, e);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        e = exp_outs(4'd0, 1'b1, 1'b0);
        total_cnt++;
        if (outs !== e) $display("FAIL reset_release: got %h expected %h", outs, e);
        else pass_cnt++;
    endtask

    task automatic test_lw();
        logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [19:0] e;
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = exp_outs(seq[i], 1'b1, 1'b0);
            total_cnt++;
            if (outs !== e) $display("FAIL lw[%0d]: got %h expected %h", i, outs, e);
            else pass_cnt++;
            if (i < 5) tick();
        end
`ifdef MULTICYCLE_PERF_EN
        total_cnt++;
        if (instret !== 32'd1) $display("FAIL lw_instret: got %0d expected 1", instret);
        else pass_cnt++;
`endif
    endtask

    task automatic test_fetch_wait();
        logic [3:0] seq [4] = '{4'd1, 4'd6, 4'd8, 4'd0};
        logic [19:0] e;
        int rd_cnt = 0;
        int ir_cnt = 0;
        opcode = OP_R;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            e = exp_outs(4'd0, mem_ready, 1'b0);
            total_cnt++;
            if (outs !== e) $display("FAIL fetch_wait[%0d]: got %h expected %h", i, outs, e);
            else pass_cnt++;
            rd_cnt += int'(mem_read);
            ir_cnt += int'(ir_write & pc_write);
            tick();
        end
        total_cnt++;
        if (rd_cnt != 4 || ir_cnt != 1)
            $display("FAIL fetch_wait_counts: got rd=%0d ir=%0d expected rd=4 ir=1", rd_cnt, ir_cnt);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            e = exp_outs(seq[i], 1'b1, 1'b0);
            total_cnt++;
            if (outs !== e) $display("FAIL rtype[%0d]: got %h expected %h", i, outs, e);
            else pass_cnt++;
            if (i < 3) tick();
        end
    endtask

    task automatic test_beq();
        logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
        logic [19:0] e;
        opcode = OP_BEQ; mem_ready = 1'b1;
        for (int z = 0; z < 2; z++) begin
            zero = (z == 0);
            for (int i = 0; i < 4; i++) begin
                e = exp_outs(seq[i], 1'b1, 1'b0);
                total_cnt++;
                if (outs !== e) $display("FAIL beq_z%0d[%0d]: got %h expected %h", z, i, outs, e);
                else pass_cnt++;
                if (i < 3) tick();
            end
        end
`ifdef MULTICYCLE_PERF_EN
        total_cnt++;
        if (instret !== 32'd4) $display("FAIL beq_instret: got %0d expected 4", instret);
        else pass_cnt++;
`endif
    endtask

    task automatic test_fault();
        logic [19:0] e;
        int bad = 0;
        opcode = OP_BAD; mem_ready = 1'b1;
        tick();
        e = exp_outs(4'd1, 1'b1, 1'b0);
        total_cnt++;
        if (outs !== e) $display("FAIL fault_decode: got %h expected %h", outs, e);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            #1;
            e = exp_outs(4'd10, mem_ready, 1'b0);
            if (outs !== e) bad++;
            tick();
        end
        total_cnt++;
        if (bad != 0) $display("FAIL fault_sticky: got %0d bad cycles expected 0", bad);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b1; opcode = OP_SW;
        #1;
        e = exp_outs(4'd0, 1'b1, 1'b0);
        total_cnt++;
        if (outs !== e) $display("FAIL fault_reset: got %h expected %h", outs, e);
        else pass_cnt++;
`ifdef MULTICYCLE_PERF_EN
        total_cnt++;
        if (instret !== 32'd0) $display("FAIL fault_instret: got %0d expected 0", instret);
        else pass_cnt++;
`endif
    endtask

    task automatic test_sw_timeout();
        logic [19:0] e;
        int bad;
        for (int rep = 0; rep < 2; rep++) begin
            opcode = OP_SW; mem_ready = 1'b1; bad = 0;
            tick(); tick();
            mem_ready = 1'b0;
            tick();
            for (int i = 0; i < 17; i++) begin
                mem_ready = (rep == 1) && (i == 16);
                #1;
                e = exp_outs(4'd5, mem_ready, 1'b0);
                if (outs !== e) bad++;
                tick();
            end
            total_cnt++;
            if (bad != 0) $display("FAIL sw_wait%0d: got %0d bad cycles expected 0", rep, bad);
            else pass_cnt++;
            mem_ready = 1'b1;
            #1;
            e = (rep == 0) ? exp_outs(4'd10, 1'b1, 1'b0) : exp_outs(4'd0, 1'b1, 1'b0);
            total_cnt++;
            if (outs !== e) $display("FAIL sw_end%0d: got %h expected %h", rep, outs, e);
            else pass_cnt++;
            if (rep == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                #1;
            end
        end
`ifdef MULTICYCLE_PERF_EN
        total_cnt++;
        if (instret !== 32'd1) $display("FAIL sw_instret: got %0d expected 1", instret);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_midaccess();
        logic [19:0] e;
        opcode = OP_LW; mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        e = exp_outs(4'd3, 1'b0, 1'b1);
        total_cnt++;
        if (outs !== e) $display("FAIL midaccess_hold: got %h expected %h", outs, e);
        else pass_cnt++;
        tick();
        e = exp_outs(4'd0, 1'b0, 1'b1);
        total_cnt++;
        if (outs !== e) $display("FAIL midaccess_fetch: got %h expected %h", outs, e);
        else pass_cnt++;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        mem_ready = 1'b1;
        tick();
        e = exp_outs(4'd1, 1'b1, 1'b0);
        total_cnt++;
        if (outs !== e) $display("FAIL midaccess_counter: got %h expected %h", outs, e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_wait();
        test_beq();
        test_fault();
        test_sw_timeout();
        test_reset_midaccess();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
